// File: rtl/vga_canvas_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_canvas_scan: VGA scan generator emitting scaled canvas coordinates
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_canvas_scan #(
    parameter int CLK_DIV     = 4,
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int PIPE_DELAY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixelTick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       activeRaw,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       frameStart
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0]      H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0]      V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0]      HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0]      HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0]      VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0]      VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic             frameStart_q, frameStart_d;
    logic [10:0]      hWide, vWide;
    logic             hsRaw, vsRaw;

    assign pixelTick = (divCnt_q == DIV_LAST) && !rst;

    always_comb begin
        divCnt_d     = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + 1'b1;
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        frameStart_d = 1'b0;
        if (pixelTick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d     = '0;
                    frameStart_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divCnt_q     <= '0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            frameStart_q <= 1'b0;
        end else begin
            divCnt_q     <= divCnt_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign frameStart = frameStart_q;
    assign x          = hcount_q >> SCALE_SHIFT;
    assign y          = vcount_q >> SCALE_SHIFT;
    assign hWide      = {1'b0, hcount_q};
    assign vWide      = {1'b0, vcount_q};
    assign activeRaw  = (hWide < H_VIS) && (vWide < V_VIS);
    assign hsRaw      = !((hWide >= HS_START) && (hWide < HS_END));
    assign vsRaw      = !((vWide >= VS_START) && (vWide < VS_END));

    // Delay runs every clk so sync/active match the registered sprite and palette stages
    generate
        if (PIPE_DELAY == 0) begin : g_direct
            assign hsync  = hsRaw;
            assign vsync  = vsRaw;
            assign active = activeRaw;
        end else begin : g_pipe
            logic [2:0] pipe_q [PIPE_DELAY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        pipe_q[i] <= 3'b110;
                    end
                end else begin
                    pipe_q[0] <= {hsRaw, vsRaw, activeRaw};
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign {hsync, vsync, active} = pipe_q[PIPE_DELAY-1];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_vga_canvas_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_canvas_scan: self-checking bench for vga_canvas_scan
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vga_canvas_scan;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    // u0: full 640x480 timing; u1/u2: shrunken 24x14 frame for whole-frame checks
    logic       t0, ar0, hs0, vs0, ac0, fs0;
    logic [9:0] x0, y0;
    logic       t1, ar1, hs1, vs1, ac1, fs1;
    logic [9:0] x1, y1;
    logic       t2, ar2, hs2, vs2, ac2, fs2;
    logic [9:0] x2, y2;

    vga_canvas_scan u0 (
        .clk(clk), .rst(rst_a), .pixelTick(t0), .x(x0), .y(y0), .activeRaw(ar0),
        .hsync(hs0), .vsync(vs0), .active(ac0), .frameStart(fs0)
    );

    vga_canvas_scan #(
        .CLK_DIV(1), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .SCALE_SHIFT(2), .PIPE_DELAY(0)
    ) u1 (
        .clk(clk), .rst(rst_b), .pixelTick(t1), .x(x1), .y(y1), .activeRaw(ar1),
        .hsync(hs1), .vsync(vs1), .active(ac1), .frameStart(fs1)
    );

    vga_canvas_scan #(
        .CLK_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .SCALE_SHIFT(2), .PIPE_DELAY(3)
    ) u2 (
        .clk(clk), .rst(rst_b), .pixelTick(t2), .x(x2), .y(y2), .activeRaw(ar2),
        .hsync(hs2), .vsync(vs2), .active(ac2), .frameStart(fs2)
    );

    logic       sel;
    logic       m_t, m_ar, m_hs, m_vs, m_ac, m_fs;
    logic [9:0] m_x, m_y;
    assign m_t  = sel ? t2  : t1;
    assign m_ar = sel ? ar2 : ar1;
    assign m_hs = sel ? hs2 : hs1;
    assign m_vs = sel ? vs2 : vs1;
    assign m_ac = sel ? ac2 : ac1;
    assign m_fs = sel ? fs2 : fs1;
    assign m_x  = sel ? x2  : x1;
    assign m_y  = sel ? y2  : y1;

    typedef struct {
        int k; int tick; int x; int y; int ar; int hs; int vs; int act; int fs;
    } vec_t;

    vec_t tbl [17];
    vec_t sb [$];
    int checks = 0;
    int errors = 0;
    int k, ticks, hslow, prevx, runlen, xbad;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic adv0();
        @(negedge clk);
        k++;
        if (k < 3200) begin
            ticks += int'(t0);
            hslow += int'(!hs0);
            if (int'(x0) == prevx) begin
                runlen++;
            end else begin
                if (runlen != 16 || int'(x0) != prevx + 1) xbad++;
                prevx  = int'(x0);
                runlen = 1;
            end
        end else if (k == 3200) begin
            if (runlen != 16 || prevx != 199) xbad++;
        end
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (m_fs) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Walks one whole frame from a frameStart pulse, measuring edges and counts
    task automatic measure(input string tag, input int cdiv,
                           input int eAr, input int eAc, input int eHs, input int eVs);
        bit ok;
        int period, vsl, hsl, arc, tk, fsc, ybad, fAr, fAc, fHs, fVs;
        logic pAr, pAc, pHs, pVs;
        period = 336 * cdiv;
        vsl = 0; hsl = 0; arc = 0; tk = 0; fsc = 0; ybad = 0;
        fAr = -1; fAc = -1; fHs = -1; fVs = -1;
        pAr = 1'b0; pAc = 1'b0; pHs = 1'b0; pVs = 1'b0;
        wait_fs(ok);
        chk({tag, "_fs_found"}, int'(ok), 1);
        chk({tag, "_x_at_start"}, int'(m_x), 0);
        chk({tag, "_y_at_start"}, int'(m_y), 0);
        for (int off = 0; off <= period; off++) begin
            if (off > 0) @(negedge clk);
            if (off < period) begin
                vsl += int'(!m_vs);
                hsl += int'(!m_hs);
                arc += int'(m_ar);
                tk  += int'(m_t);
                if (off > 0) fsc += int'(m_fs);
                if (!sel && !m_vs && m_y != 10'd2) ybad++;
                if (off > 0) begin
                    if (fAr < 0 && pAr && !m_ar) fAr = off;
                    if (fAc < 0 && pAc && !m_ac) fAc = off;
                    if (fHs < 0 && pHs && !m_hs) fHs = off;
                    if (fVs < 0 && pVs && !m_vs) fVs = off;
                end
                if (off == 183 * cdiv) begin
                    chk({tag, "_bound_x"}, int'(m_x), 3);
                    chk({tag, "_bound_y"}, int'(m_y), 1);
                    chk({tag, "_bound_ar"}, int'(m_ar), 1);
                end
                if (off == 184 * cdiv) chk({tag, "_bound_ar_next"}, int'(m_ar), 0);
                pAr = m_ar; pAc = m_ac; pHs = m_hs; pVs = m_vs;
            end else begin
                chk({tag, "_fs_period"}, int'(m_fs), 1);
            end
        end
        chk({tag, "_fs_extra"}, fsc, 0);
        chk({tag, "_ticks"}, tk, 336);
        chk({tag, "_vsync_low_clks"}, vsl, 48 * cdiv);
        chk({tag, "_hsync_low_clks"}, hsl, 42 * cdiv);
        chk({tag, "_active_raw_clks"}, arc, 128 * cdiv);
        chk({tag, "_y_during_vsync"}, ybad, 0);
        chk({tag, "_ar_fall_off"}, fAr, eAr);
        chk({tag, "_active_fall_off"}, fAc, eAc);
        chk({tag, "_hsync_fall_off"}, fHs, eHs);
        chk({tag, "_vsync_fall_off"}, fVs, eVs);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int fsc;
        vec_t e;
        //           k      tick x    y  ar hs vs act fs
        tbl[0]  = '{1,      0,   0,   0, 1, 1, 1, 0,  0};
        tbl[1]  = '{2,      0,   0,   0, 1, 1, 1, 1,  0};
        tbl[2]  = '{3,      1,   0,   0, 1, 1, 1, 1,  0};
        tbl[3]  = '{4,      0,   0,   0, 1, 1, 1, 1,  0};
        tbl[4]  = '{15,     1,   0,   0, 1, 1, 1, 1,  0};
        tbl[5]  = '{16,     0,   1,   0, 1, 1, 1, 1,  0};
        tbl[6]  = '{2559,   1,   159, 0, 1, 1, 1, 1,  0};
        tbl[7]  = '{2560,   0,   160, 0, 0, 1, 1, 1,  0};
        tbl[8]  = '{2562,   0,   160, 0, 0, 1, 1, 0,  0};
        tbl[9]  = '{2625,   0,   164, 0, 0, 1, 1, 0,  0};
        tbl[10] = '{2626,   0,   164, 0, 0, 0, 1, 0,  0};
        tbl[11] = '{3009,   0,   188, 0, 0, 0, 1, 0,  0};
        tbl[12] = '{3010,   0,   188, 0, 0, 1, 1, 0,  0};
        tbl[13] = '{3199,   1,   199, 0, 0, 1, 1, 0,  0};
        tbl[14] = '{3200,   0,   0,   0, 1, 1, 1, 0,  0};
        tbl[15] = '{3202,   0,   0,   0, 1, 1, 1, 1,  0};
        tbl[16] = '{12800,  0,   0,   1, 1, 1, 1, 0,  0};

        sel   = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tick", int'(t0), 0);
        chk("rst_x", int'(x0), 0);
        chk("rst_y", int'(y0), 0);
        chk("rst_ar", int'(ar0), 1);
        chk("rst_hsync", int'(hs0), 1);
        chk("rst_vsync", int'(vs0), 1);
        chk("rst_active", int'(ac0), 0);
        chk("rst_fs", int'(fs0), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        k = 0; ticks = 0; hslow = 0; prevx = 0; runlen = 1; xbad = 0;
        for (int i = 0; i < 17; i++) begin
            sb.push_back(tbl[i]);
            while (k < tbl[i].k) adv0();
            e = sb.pop_front();
            chk($sformatf("k%0d_tick", e.k), int'(t0), e.tick);
            chk($sformatf("k%0d_x", e.k), int'(x0), e.x);
            chk($sformatf("k%0d_y", e.k), int'(y0), e.y);
            chk($sformatf("k%0d_ar", e.k), int'(ar0), e.ar);
            chk($sformatf("k%0d_hsync", e.k), int'(hs0), e.hs);
            chk($sformatf("k%0d_vsync", e.k), int'(vs0), e.vs);
            chk($sformatf("k%0d_active", e.k), int'(ac0), e.act);
            chk($sformatf("k%0d_fs", e.k), int'(fs0), e.fs);
        end
        chk("line_ticks", ticks, 800);
        chk("line_hsync_low_clks", hslow, 384);
        chk("line_x_hold", xbad, 0);

        sel = 1'b0;
        measure("d0", 1, 16, 16, 18, 240);
        sel = 1'b1;
        measure("d3", 2, 32, 35, 39, 483);

        // Reset in the middle of a frame: no stray wrap, full frame before next pulse
        sel = 1'b0;
        wait_fs(ok);
        chk("mid_fs_found", int'(ok), 1);
        repeat (130) @(negedge clk);
        chk("mid_x_before", int'(x1), 2);
        chk("mid_y_before", int'(y1), 1);
        rst_b = 1'b1;
        @(negedge clk);
        chk("mid_x", int'(x1), 0);
        chk("mid_y", int'(y1), 0);
        chk("mid_tick", int'(t1), 0);
        chk("mid_fs", int'(fs1), 0);
        chk("mid_hsync_d3", int'(hs2), 1);
        chk("mid_vsync_d3", int'(vs2), 1);
        chk("mid_active_d3", int'(ac2), 0);
        chk("mid_fs_d3", int'(fs2), 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        fsc = 0;
        for (int n = 1; n <= 336; n++) begin
            @(negedge clk);
            if (n < 336) fsc += int'(fs1);
            else chk("mid_first_fs", int'(fs1), 1);
        end
        chk("mid_no_early_fs", fsc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
